// File: rtl/sb_param_cfg_if.sv
// Routing-side bundle of the switch block: incoming tracks, grid pins and driven tracks.
// The master is the fabric side that drives tracks and pins. The slave is the switch block.
interface sb_param_cfg_if #(
    parameter int W = 8,
    parameter int P = 2
);
    logic [W-1:0] chan_top_in;
    logic [W-1:0] chan_right_in;
    logic [W-1:0] chan_bottom_in;
    logic [W-1:0] chan_left_in;
    logic [P-1:0] pin_top_in;
    logic [P-1:0] pin_right_in;
    logic [P-1:0] pin_bottom_in;
    logic [P-1:0] pin_left_in;
    logic [W-1:0] chan_top_out;
    logic [W-1:0] chan_right_out;
    logic [W-1:0] chan_bottom_out;
    logic [W-1:0] chan_left_out;

    modport master (
        output chan_top_in, chan_right_in, chan_bottom_in, chan_left_in,
        output pin_top_in, pin_right_in, pin_bottom_in, pin_left_in,
        input  chan_top_out, chan_right_out, chan_bottom_out, chan_left_out
    );

    modport slave (
        input  chan_top_in, chan_right_in, chan_bottom_in, chan_left_in,
        input  pin_top_in, pin_right_in, pin_bottom_in, pin_left_in,
        output chan_top_out, chan_right_out, chan_bottom_out, chan_left_out
    );
endinterface

// File: rtl/sb_param_cfg.sv
// Four-sided FPGA switch block. Each output track has a 4:1 mux, and its select comes from a serial config chain.
// Routing outputs stay at zero until a complete configuration has been shifted in.
module sb_param_cfg #(
    parameter int W       = 8,
    parameter int P       = 2,
    parameter int REG_OUT = 0
) (
    input  logic           prog_clk,
    input  logic           prog_reset,
    input  logic           cfg_en,
    input  logic           ccff_head,
    output logic           ccff_tail,
    output logic           cfg_done,
    sb_param_cfg_if.slave  bus
);
    localparam int N  = 8 * W;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_UNCFG   = 2'd0,
        ST_LOADING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic [N-1:0]          cfg_r;
    logic                  cfg_done_r;
    logic [3:0][W-1:0]     chan_in_s;
    logic [3:0][P-1:0]     pin_in_s;
    logic [3:0][W-1:0]     route_s;
    logic [3:0][W-1:0]     gated_s;
    logic [3:0][W-1:0]     out_s;

    function automatic logic mux4(input logic [1:0] sel, input logic opp, input logic cw,
                                  input logic ccw, input logic pin);
        logic res;
        case (sel)
            2'd0:    res = opp;
            2'd1:    res = cw;
            2'd2:    res = ccw;
            2'd3:    res = pin;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign chan_in_s[0] = bus.chan_top_in;
    assign chan_in_s[1] = bus.chan_right_in;
    assign chan_in_s[2] = bus.chan_bottom_in;
    assign chan_in_s[3] = bus.chan_left_in;
    assign pin_in_s[0]  = bus.pin_top_in;
    assign pin_in_s[1]  = bus.pin_right_in;
    assign pin_in_s[2]  = bus.pin_bottom_in;
    assign pin_in_s[3]  = bus.pin_left_in;

    // Side s is 0=top, 1=right, 2=bottom, 3=left. The counter-clockwise turn mirrors the track index.
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < W; t++) begin : g_track
            localparam int M = s * W + t;
            assign route_s[s][t] = mux4(cfg_r[2*M+1:2*M],
                                        chan_in_s[(s+2)%4][t],
                                        chan_in_s[(s+1)%4][t],
                                        chan_in_s[(s+3)%4][W-1-t],
                                        pin_in_s[s][t%P]);
        end
    end

    assign gated_s = (state_r == ST_ACTIVE) ? route_s : '0;

    // Configuration shift register: bit 0 takes the head, and the oldest bit leaves at the tail.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            cfg_r <= '0;
        end else if (cfg_en) begin
            cfg_r <= {cfg_r[N-2:0], ccff_head};
        end else begin
            cfg_r <= cfg_r;
        end
    end

    // Load controller: counts shifted bits and raises cfg_done when a full chain is present.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_r    <= ST_UNCFG;
            cnt_r      <= '0;
            cfg_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_UNCFG: begin
                    if (cfg_en) begin
                        state_r <= ST_LOADING;
                        cnt_r   <= CW'(1);
                    end
                end
                ST_LOADING: begin
                    if (cfg_en) begin
                        if (cnt_r == CW'(N - 1)) begin
                            state_r    <= ST_ACTIVE;
                            cnt_r      <= '0;
                            cfg_done_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (cfg_en) begin
                        state_r    <= ST_LOADING;
                        cnt_r      <= CW'(1);
                        cfg_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_UNCFG;
                    cnt_r      <= '0;
                    cfg_done_r <= 1'b0;
                end
            endcase
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [3:0][W-1:0] out_r;
        // Pipelined fabric: the gated routing value appears one prog_clk edge later.
        always_ff @(posedge prog_clk or posedge prog_reset) begin
            if (prog_reset) begin
                out_r <= '0;
            end else begin
                out_r <= gated_s;
            end
        end
        assign out_s = out_r;
    end else begin : g_comb_out
        assign out_s = gated_s;
    end

    assign bus.chan_top_out    = out_s[0];
    assign bus.chan_right_out  = out_s[1];
    assign bus.chan_bottom_out = out_s[2];
    assign bus.chan_left_out   = out_s[3];
    assign ccff_tail           = cfg_r[N-1];
    assign cfg_done            = cfg_done_r;
endmodule
